// File: rtl/cpu_step_sequencer_pkg.sv
// rtl/cpu_step_sequencer_pkg.sv - shared opcodes, FSM states and constants for the CPU step sequencer
// Purpose: single source of the command opcode map, sequencer state encoding,
//          response halt bit position and the phase timer width.
// Ports:   none (package).
package cpu_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_WADDR   = 4'd1,
        OP_RADDR   = 4'd2,
        OP_WBUS    = 4'd3,
        OP_RBUS    = 4'd4,
        OP_RFLAGS  = 4'd5,
        OP_RELEASE = 4'd6,
        OP_OFF     = 4'd7,
        OP_SETCW   = 4'd8,
        OP_CLK     = 4'd9,
        OP_ICLK    = 4'd10,
        OP_TICK    = 4'd11,
        OP_ROPC    = 4'd12,
        OP_RUN     = 4'd13
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        CLK_HI,
        CLK_LO,
        ICLK_HI,
        ICLK_LO,
        RESP
    } state_e;

    localparam int RSP_HALT_BIT = 31;
    localparam int TIMER_W      = 16;

endpackage

// File: rtl/cpu_step_sequencer_if.sv
// rtl/cpu_step_sequencer_if.sv - command/response handshake bundle between front-end and sequencer
// Purpose: groups the command (valid/ready/op/arg) and response (valid/ready/data) channels.
// Ports:   cmd_valid, cmd_ready, cmd_op[3:0], cmd_arg[31:0],
//          rsp_valid, rsp_ready, rsp_data[31:0].
//          master = serial front-end side, slave = sequencer side.
interface cpu_step_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/cpu_step_sequencer_phase_timer.sv
// rtl/cpu_step_sequencer_phase_timer.sv - loadable down-counter timing clock phases and gaps
// Purpose: counts the system-clock cycles spent in one sequencer phase.
// Ports:   clk, rst (async, active-high), load (reload count), load_val[W-1:0],
//          done (high during the last cycle of the loaded interval).
module phase_timer
    import cpu_seq_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Loading N-1 on phase entry makes done true in the Nth cycle of the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/cpu_step_sequencer.sv
// rtl/cpu_step_sequencer.sv - host-side debug controller sequencing CPU clock phases and bus drive
// Purpose: accepts single-op commands, drives the CPU control word, address/data bus
//          overrides and the two CPU clock phases, and returns read/run results.
// Ports:   clk, rst (async, active-high), host (command/response handshake, slave),
//          cpu_clk, cpu_iclk, ctrl_word[31:0], ctrlen, data_out[7:0], data_oe,
//          addr_out[15:0], addr_oe, main_bus_in[7:0], addr_bus_in[15:0],
//          flags_in[3:0], opcode_in[7:0], halt_in.
module cpu_step_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int RUN_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_step_sequencer_if.slave   host,
    output logic                  cpu_clk,
    output logic                  cpu_iclk,
    output logic [31:0]           ctrl_word,
    output logic                  ctrlen,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    output logic [15:0]           addr_out,
    output logic                  addr_oe,
    input  logic [7:0]            main_bus_in,
    input  logic [15:0]           addr_bus_in,
    input  logic [3:0]            flags_in,
    input  logic [7:0]            opcode_in,
    input  logic                  halt_in
);

    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

    state_e             state, state_n;
    logic               cmd_ready_q, cmd_ready_n;
    logic               rsp_valid_q, rsp_valid_n;
    logic [31:0]        rsp_data_q, rsp_data_n;
    logic [31:0]        ctrl_word_n;
    logic [7:0]         data_out_n;
    logic               data_oe_n;
    logic [15:0]        addr_out_n;
    logic               addr_oe_n;
    logic               full_tick, full_tick_n;     // CLK_LO continues into the iclk phase
    logic               run_mode, run_mode_n;       // ticks repeat until count or halt
    logic [RUN_W-1:0]   remaining, remaining_n;
    logic [RUN_W-1:0]   executed, executed_n;
    logic [RUN_W-1:0]   remaining_dec, executed_inc;
    logic               accept;
    logic               phase_done;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;

    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;

    assign accept = host.cmd_valid & cmd_ready_q;

    // Every state change starts a fresh phase interval; high phases use the
    // pulse width, everything else the gap width (value unused outside phases).
    assign timer_load = (state_n != state);
    assign timer_val  = ((state_n == CLK_HI) || (state_n == ICLK_HI)) ? PULSE_LOAD : GAP_LOAD;

    phase_timer #(.W(TIMER_W)) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (phase_done)
    );

    always_comb begin
        state_n       = state;
        ctrl_word_n   = ctrl_word;
        data_out_n    = data_out;
        data_oe_n     = data_oe;
        addr_out_n    = addr_out;
        addr_oe_n     = addr_oe;
        rsp_valid_n   = rsp_valid_q;
        rsp_data_n    = rsp_data_q;
        full_tick_n   = full_tick;
        run_mode_n    = run_mode;
        remaining_n   = remaining;
        executed_n    = executed;
        remaining_dec = remaining - 1'b1;
        executed_inc  = executed + 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (host.cmd_op)
                        OP_WADDR: begin
                            addr_out_n = host.cmd_arg[15:0];
                            addr_oe_n  = 1'b1;
                        end
                        OP_WBUS: begin
                            data_out_n = host.cmd_arg[7:0];
                            data_oe_n  = 1'b1;
                        end
                        OP_RELEASE: begin
                            addr_oe_n = 1'b0;
                            data_oe_n = 1'b0;
                        end
                        OP_SETCW: ctrl_word_n = host.cmd_arg;
                        OP_OFF: begin
                            addr_oe_n   = 1'b0;
                            data_oe_n   = 1'b0;
                            ctrl_word_n = host.cmd_arg;
                        end
                        OP_RADDR: begin
                            rsp_valid_n = 1'b1;
                            rsp_data_n  = {16'h0, addr_bus_in};
                            state_n     = RESP;
                        end
                        OP_RBUS: begin
                            rsp_valid_n = 1'b1;
                            rsp_data_n  = {24'h0, main_bus_in};
                            state_n     = RESP;
                        end
                        OP_RFLAGS: begin
                            rsp_valid_n = 1'b1;
                            rsp_data_n  = {28'h0, flags_in};
                            state_n     = RESP;
                        end
                        OP_ROPC: begin
                            rsp_valid_n = 1'b1;
                            rsp_data_n  = {24'h0, opcode_in};
                            state_n     = RESP;
                        end
                        OP_CLK: begin
                            full_tick_n = 1'b0;
                            run_mode_n  = 1'b0;
                            state_n     = CLK_HI;
                        end
                        OP_ICLK: begin
                            run_mode_n = 1'b0;
                            state_n    = ICLK_HI;
                        end
                        OP_TICK: begin
                            full_tick_n = 1'b1;
                            run_mode_n  = 1'b0;
                            state_n     = CLK_HI;
                        end
                        OP_RUN: begin
                            full_tick_n = 1'b1;
                            run_mode_n  = 1'b1;
                            executed_n  = '0;
                            // A zero count still runs one tick.
                            remaining_n = (host.cmd_arg[RUN_W-1:0] == '0) ?
                                          RUN_W'(1) : host.cmd_arg[RUN_W-1:0];
                            state_n     = CLK_HI;
                        end
                        default: ;
                    endcase
                end
            end
            CLK_HI: begin
                if (phase_done) state_n = CLK_LO;
            end
            CLK_LO: begin
                if (phase_done) state_n = full_tick ? ICLK_HI : IDLE;
            end
            ICLK_HI: begin
                if (phase_done) state_n = ICLK_LO;
            end
            ICLK_LO: begin
                if (phase_done) begin
                    if (run_mode) begin
                        // Halt is only looked at here, so a started tick always finishes.
                        executed_n  = executed_inc;
                        remaining_n = remaining_dec;
                        if (halt_in || (remaining_dec == '0)) begin
                            run_mode_n               = 1'b0;
                            rsp_valid_n              = 1'b1;
                            rsp_data_n               = 32'(executed_inc);
                            rsp_data_n[RSP_HALT_BIT] = halt_in;
                            state_n                  = RESP;
                        end else begin
                            state_n = CLK_HI;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            RESP: begin
                if (host.rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    rsp_data_n  = '0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        cmd_ready_n = (state_n == IDLE) & ~rsp_valid_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cpu_clk     <= 1'b0;
            cpu_iclk    <= 1'b0;
            ctrl_word   <= '0;
            ctrlen      <= 1'b1;
            data_out    <= '0;
            data_oe     <= 1'b0;
            addr_out    <= '0;
            addr_oe     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b0;
            full_tick   <= 1'b0;
            run_mode    <= 1'b0;
            remaining   <= '0;
            executed    <= '0;
        end else begin
            state       <= state_n;
            // Clock levels derive from the next state alone, so they can never overlap.
            cpu_clk     <= (state_n == CLK_HI);
            cpu_iclk    <= (state_n == ICLK_HI);
            ctrl_word   <= ctrl_word_n;
            ctrlen      <= 1'b1;
            data_out    <= data_out_n;
            data_oe     <= data_oe_n;
            addr_out    <= addr_out_n;
            addr_oe     <= addr_oe_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_data_q  <= rsp_data_n;
            cmd_ready_q <= cmd_ready_n;
            full_tick   <= full_tick_n;
            run_mode    <= run_mode_n;
            remaining   <= remaining_n;
            executed    <= executed_n;
        end
    end

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// tb/tb_cpu_step_sequencer.sv - self-checking bench for cpu_step_sequencer
module tb_cpu_step_sequencer;
    import cpu_seq_pkg::*;

    localparam int P = 2;
    localparam int G = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_step_sequencer_if hif();

    logic        cpu_clk, cpu_iclk, ctrlen, data_oe, addr_oe;
    logic [31:0] ctrl_word;
    logic [7:0]  data_out;
    logic [15:0] addr_out;
    logic [7:0]  main_bus_in, bus_float, opcode_in;
    logic [15:0] addr_bus_in, addr_float;
    logic [3:0]  flags_in;
    logic        halt_in;
    logic        rnd_en;

    assign main_bus_in = data_oe ? data_out : bus_float;
    assign addr_bus_in = addr_oe ? addr_out : addr_float;

    cpu_step_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .RUN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hif),
        .cpu_clk     (cpu_clk),
        .cpu_iclk    (cpu_iclk),
        .ctrl_word   (ctrl_word),
        .ctrlen      (ctrlen),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .addr_out    (addr_out),
        .addr_oe     (addr_oe),
        .main_bus_in (main_bus_in),
        .addr_bus_in (addr_bus_in),
        .flags_in    (flags_in),
        .opcode_in   (opcode_in),
        .halt_in     (halt_in)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_clk = 0, m_iclk = 0, m_data_oe = 0, m_addr_oe = 0;
    logic        m_rsp_valid = 0, m_cmd_ready = 0, m_busy = 0, m_in_run = 0;
    logic [31:0] m_ctrl_word = 0, m_rsp_data = 0;
    logic [7:0]  m_data_out = 0;
    logic [15:0] m_addr_out = 0;
    int          m_run_total = 0, m_run_done = 0;
    logic        q_clk[$];
    logic        q_iclk[$];

    task automatic push_phase(input logic c, input logic i, input int n);
        for (int k = 0; k < n; k++) begin
            q_clk.push_back(c);
            q_iclk.push_back(i);
        end
    endtask

    task automatic push_tick();
        push_phase(1'b1, 1'b0, P);
        push_phase(1'b0, 1'b0, G);
        push_phase(1'b0, 1'b1, P);
        push_phase(1'b0, 1'b0, G);
    endtask

    task automatic model_reset();
        m_clk = 0; m_iclk = 0; m_data_oe = 0; m_addr_oe = 0;
        m_rsp_valid = 0; m_cmd_ready = 0; m_busy = 0; m_in_run = 0;
        m_ctrl_word = 0; m_rsp_data = 0; m_data_out = 0; m_addr_out = 0;
        q_clk.delete();
        q_iclk.delete();
    endtask

    task automatic model_accept(input logic [3:0] op, input logic [31:0] arg);
        case (op)
            OP_WADDR:   begin m_addr_out = arg[15:0]; m_addr_oe = 1; end
            OP_WBUS:    begin m_data_out = arg[7:0]; m_data_oe = 1; end
            OP_RELEASE: begin m_addr_oe = 0; m_data_oe = 0; end
            OP_SETCW:   m_ctrl_word = arg;
            OP_OFF:     begin m_addr_oe = 0; m_data_oe = 0; m_ctrl_word = arg; end
            OP_RADDR:   begin m_rsp_valid = 1; m_rsp_data = {16'h0, addr_bus_in}; end
            OP_RBUS:    begin m_rsp_valid = 1; m_rsp_data = {24'h0, main_bus_in}; end
            OP_RFLAGS:  begin m_rsp_valid = 1; m_rsp_data = {28'h0, flags_in}; end
            OP_ROPC:    begin m_rsp_valid = 1; m_rsp_data = {24'h0, opcode_in}; end
            OP_CLK:     begin push_phase(1'b1, 1'b0, P); push_phase(1'b0, 1'b0, G); m_busy = 1; end
            OP_ICLK:    begin push_phase(1'b0, 1'b1, P); push_phase(1'b0, 1'b0, G); m_busy = 1; end
            OP_TICK:    begin push_tick(); m_busy = 1; end
            OP_RUN: begin
                m_run_total = (arg[15:0] == 16'h0) ? 1 : int'(arg[15:0]);
                m_run_done  = 0;
                m_in_run    = 1;
                push_tick();
                m_busy      = 1;
            end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            model_reset();
        end else begin
            if (m_busy && q_clk.size() == 0) begin
                m_busy = 0;
                if (m_in_run) begin
                    m_run_done++;
                    if (halt_in || m_run_done >= m_run_total) begin
                        m_in_run    = 0;
                        m_rsp_valid = 1;
                        m_rsp_data  = {halt_in, 15'h0, 16'(m_run_done)};
                    end else begin
                        push_tick();
                        m_busy = 1;
                    end
                end
            end else if (m_rsp_valid) begin
                if (hif.rsp_ready) begin
                    m_rsp_valid = 0;
                    m_rsp_data  = 0;
                end
            end else if (m_cmd_ready && hif.cmd_valid) begin
                model_accept(hif.cmd_op, hif.cmd_arg);
            end
            if (q_clk.size() > 0) begin
                m_clk  = q_clk.pop_front();
                m_iclk = q_iclk.pop_front();
            end else begin
                m_clk  = 0;
                m_iclk = 0;
            end
            m_cmd_ready = !m_busy && !m_rsp_valid;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("cpu_clk",   cpu_clk,       m_clk);
        chk("cpu_iclk",  cpu_iclk,      m_iclk);
        chk("no_overlap", cpu_clk & cpu_iclk, 1'b0);
        chk("ctrl_word", ctrl_word,     m_ctrl_word);
        chk("ctrlen",    ctrlen,        1'b1);
        chk("data_out",  data_out,      m_data_out);
        chk("data_oe",   data_oe,       m_data_oe);
        chk("addr_out",  addr_out,      m_addr_out);
        chk("addr_oe",   addr_oe,       m_addr_oe);
        chk("cmd_ready", hif.cmd_ready, m_cmd_ready);
        chk("rsp_valid", hif.rsp_valid, m_rsp_valid);
        chk("rsp_data",  hif.rsp_data,  m_rsp_data);
    end

    // ---------------- pulse monitor ----------------
    int   clk_hi_cnt = 0, iclk_hi_cnt = 0, clk_rise = 0, iclk_rise = 0;
    logic prev_clk = 0, prev_iclk = 0;

    initial forever begin
        @(negedge clk);
        if (cpu_clk) clk_hi_cnt++;
        if (cpu_iclk) iclk_hi_cnt++;
        if (cpu_clk && !prev_clk) clk_rise++;
        if (cpu_iclk && !prev_iclk) iclk_rise++;
        prev_clk  = cpu_clk;
        prev_iclk = cpu_iclk;
    end

    task automatic clear_counts();
        clk_hi_cnt = 0; iclk_hi_cnt = 0; clk_rise = 0; iclk_rise = 0;
    endtask

    // ---------------- random environment ----------------
    initial forever begin
        @(negedge clk);
        if (rnd_en) begin
            bus_float     = 8'($urandom);
            addr_float    = 16'($urandom);
            flags_in      = 4'($urandom);
            opcode_in     = 8'($urandom);
            halt_in       = ($urandom_range(0, 7) == 0);
            hif.rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [3:0] op, input logic [31:0] arg);
        int n = 0;
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_arg   = arg;
        while (hif.cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL cmd_accept_timeout: op %0d waited %0d cycles, limit 5000", op, n);
        end
        @(negedge clk);
        hif.cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] data);
        int n = 0;
        while (hif.rsp_valid !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL rsp_timeout: waited %0d cycles, limit 5000", n);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("rsp_valid_hold", hif.rsp_valid, 1'b1);
        end
        data = hif.rsp_data;
        hif.rsp_ready = 1'b1;
        @(negedge clk);
        hif.rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [31:0] d;
        int          n;
        logic [3:0]  op;
        logic [31:0] arg;

        hif.cmd_valid = 0; hif.cmd_op = 0; hif.cmd_arg = 0; hif.rsp_ready = 0;
        bus_float = 8'h3C; addr_float = 16'h7E11; flags_in = 4'h9; opcode_in = 8'h4D;
        halt_in = 0; rnd_en = 0;

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", hif.cmd_ready, 1'b0);
        chk("reset_ctrlen", ctrlen, 1'b1);
        chk("reset_rsp_valid", hif.rsp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", hif.cmd_ready, 1'b1);

        // bus write then loopback read, response held while not consumed
        send_cmd(OP_WBUS, 32'h0000_00A5);
        chk("wbus_data_oe", data_oe, 1'b1);
        send_cmd(OP_RBUS, 32'h0);
        get_rsp(3, d);
        chk("rbus_loop", d, 32'h0000_00A5);
        send_cmd(OP_RFLAGS, 32'h0);
        get_rsp(0, d);
        chk("rflags", d, 32'h0000_0009);

        // single tick timing
        clear_counts();
        send_cmd(OP_TICK, 32'h0);
        n = 0;
        while (hif.cmd_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("tick_busy_cycles", n, 10);
        chk("tick_clk_hi", clk_hi_cnt, P);
        chk("tick_iclk_hi", iclk_hi_cnt, P);

        // free run of five ticks
        clear_counts();
        send_cmd(OP_RUN, 32'd5);
        get_rsp(0, d);
        chk("run5_rsp", d, 32'h0000_0005);
        chk("run5_clk_pulses", clk_rise, 5);
        chk("run5_iclk_pulses", iclk_rise, 5);

        // halt raised in the middle of the third tick
        clear_counts();
        send_cmd(OP_RUN, 32'd100);
        repeat (22) @(negedge clk);
        halt_in = 1'b1;
        get_rsp(0, d);
        halt_in = 1'b0;
        chk("run_halt_rsp", d, 32'h8000_0003);
        chk("run_halt_clk_pulses", clk_rise, 3);
        chk("run_halt_iclk_pulses", iclk_rise, 3);

        // OFF drops both enables and loads the control word together
        send_cmd(OP_WADDR, 32'h0000_1234);
        send_cmd(OP_WBUS, 32'h0000_005A);
        chk("pre_off_addr_oe", addr_oe, 1'b1);
        send_cmd(OP_OFF, 32'h1234_5678);
        chk("off_addr_oe", addr_oe, 1'b0);
        chk("off_data_oe", data_oe, 1'b0);
        chk("off_ctrl_word", ctrl_word, 32'h1234_5678);

        clear_counts();
        send_cmd(OP_RUN, 32'h0);
        get_rsp(0, d);
        chk("run0_rsp", d, 32'h0000_0001);
        chk("run0_clk_pulses", clk_rise, 1);

        // randomized command stream against the model
        rnd_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op  = 4'($urandom_range(0, 15));
            arg = $urandom;
            if (op == OP_RUN) arg = 32'($urandom_range(0, 4));
            send_cmd(op, arg);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rnd_en = 1'b0;
        halt_in = 1'b0;
        hif.rsp_ready = 1'b1;
        repeat (60) @(negedge clk);
        hif.rsp_ready = 1'b0;
        @(negedge clk);

        // asynchronous reset in the middle of a clock pulse
        send_cmd(OP_SETCW, 32'hCAFE_F00D);
        send_cmd(OP_WADDR, 32'h0000_BEEF);
        send_cmd(OP_TICK, 32'h0);
        n = 0;
        while (cpu_clk !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_cpu_clk", cpu_clk, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cpu_clk", cpu_clk, 1'b0);
        chk("async_rst_cpu_iclk", cpu_iclk, 1'b0);
        chk("async_rst_addr_oe", addr_oe, 1'b0);
        chk("async_rst_data_oe", data_oe, 1'b0);
        chk("async_rst_ctrl_word", ctrl_word, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_cmd_ready", hif.cmd_ready, 1'b1);
        chk("after_rst_ctrl_word", ctrl_word, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_step_sequencer.md
Name: cpu_step_sequencer

Overview:
- Synthesizable host-side controller that owns the CPU's debug interface: control word, bus/address drive enables, and the two CPU clock phases (clk, iclk).
- Accepts single-op commands from the serial front-end over a valid/ready handshake.
- Sequences timed clock pulses (single phase, full tick, multi-tick run) and returns read results over a response handshake.
- Sits between the serial command decoder and the cpu instance; the only driver of cpu control inputs.

Parameters:
- PULSE_CYCLES, 1, system-clock cycles each CPU clock phase is held high (>=1).
- GAP_CYCLES, 1, system-clock cycles low after each phase before the next action (>=1).
- RUN_W, 16, width of the run tick counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_op  in  4  opcode (see package)
- cmd_arg  in  32  argument: address[15:0], data[7:0], control word[31:0] or tick count[RUN_W-1:0]
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  response payload
- cpu_clk  out  1  CPU clock
- cpu_iclk  out  1  CPU inverted/secondary clock
- ctrl_word  out  32  control word to cpu
- ctrlen  out  1  control word drive enable
- data_out  out  8  host data for main bus
- data_oe  out  1  drive main bus
- addr_out  out  16  host address for address bus
- addr_oe  out  1  drive address bus
- main_bus_in  in  8  sampled main bus
- addr_bus_in  in  16  sampled address bus
- flags_in  in  4  CPU flags
- opcode_in  in  8  CPU current opcode
- halt_in  in  1  CPU halt/break indication

Behaviour:
- Reset (async, rst=1): state IDLE; cpu_clk=0, cpu_iclk=0, ctrl_word=0, ctrlen=1, data_out=0, data_oe=0, addr_out=0, addr_oe=0, rsp_valid=0, rsp_data=0, cmd_ready=0 while rst asserted. Reset mid-pulse forces both clocks low immediately.
- cmd_ready = (state==IDLE) & ~rsp_valid. All outputs are registered.
- FSM states: IDLE, CLK_HI, CLK_LO, ICLK_HI, ICLK_LO, RESP.
- Immediate ops, accepted in IDLE, effect visible the next cycle, no response:
  - OP_WADDR: addr_out<=arg[15:0], addr_oe<=1.
  - OP_WBUS: data_out<=arg[7:0], data_oe<=1.
  - OP_RELEASE: addr_oe<=0, data_oe<=0.
  - OP_SETCW: ctrl_word<=arg.
  - OP_OFF: both oe<=0 and ctrl_word<=arg, same cycle.
  - OP_NOP: nothing.
  - Unknown ops behave as NOP.
- Read ops: capture the sample in the accept cycle, go to RESP with rsp_valid=1 the next cycle.
  - OP_RADDR: rsp_data={16'0,addr_bus_in}.
  - OP_RBUS: {24'0,main_bus_in}.
  - OP_RFLAGS: {28'0,flags_in}.
  - OP_ROPC: {24'0,opcode_in}.
  - RESP holds rsp_valid/rsp_data stable until rsp_ready; clears on the rsp_ready cycle, then returns to IDLE.
- Pulse ops:
  - OP_CLK: CLK_HI (cpu_clk=1 for PULSE_CYCLES) -> CLK_LO (GAP_CYCLES) -> IDLE.
  - OP_ICLK: ICLK_HI -> ICLK_LO -> IDLE.
  - OP_TICK: CLK_HI -> CLK_LO -> ICLK_HI -> ICLK_LO -> IDLE.
  - Never both clocks high simultaneously.
  - Phase counter reloads on each state entry.
- OP_RUN: ticks = arg[RUN_W-1:0]; 0 means 1.
  - Repeats the TICK sequence, decrementing a remaining counter at the end of each ICLK_LO.
  - Checks halt_in at the end of ICLK_LO: stop if halt_in=1 or remaining reached 0.
  - Then RESP with rsp_data = {halted bit[31], ticks executed[RUN_W-1:0]}.
  - A tick in progress always completes; halt is never checked mid-tick.
- Bus/control state persists across pulses; ctrlen stays 1 (reserved for future bus sharing).
- Simultaneous rsp_ready while not in RESP: ignored.

Decomposition:
- Package cpu_seq_pkg: op enum (OP_NOP=0, OP_WADDR, OP_RADDR, OP_WBUS, OP_RBUS, OP_RFLAGS, OP_RELEASE, OP_OFF, OP_SETCW, OP_CLK, OP_ICLK, OP_TICK, OP_ROPC, OP_RUN), state enum, RSP_HALT_BIT=31.
- One sub-module, phase_timer: loadable down-counter with a done pulse, used for PULSE/GAP timing.

Test Plan:
- Reset: assert rst mid-TICK while cpu_clk=1 -> cpu_clk=0 immediately, all oe=0, ctrl_word=0, cmd_ready=1 after release.
- OP_WBUS arg=0xA5, then OP_RBUS with main_bus_in looped from data_out -> data_oe=1, rsp_data=0x000000A5; rsp_valid held across 3 cycles of rsp_ready=0.
- PULSE=2, GAP=3, OP_TICK -> cpu_clk high exactly 2 cycles, 3 low, cpu_iclk high 2 cycles, cmd_ready returns after 10 cycles total, no clock overlap.
- OP_RUN arg=5, halt_in=0 -> 5 clk and 5 iclk pulses, rsp_data=0x00000005.
- OP_RUN arg=100, halt_in raised during tick 3 -> tick 3 completes, rsp_data=0x80000003.
- OP_OFF arg=0x12345678 after WADDR/WBUS -> addr_oe=data_oe=0 and ctrl_word=0x12345678 on the same cycle; an OP_RUN with arg=0 yields exactly 1 tick.
